// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer sharing one add-shift multiplier among N_REQ requesters.
// It follows the multiplier's ready drop/rise handshake, and a watchdog aborts the operation if the multiplier hangs.
module mult_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 4,
  parameter int TIMEOUT = 15,
  localparam int IDW    = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*DW-1:0]     rsp_data,
  output logic                mult_start,
  output logic [DW-1:0]       mult_a,
  output logic [DW-1:0]       mult_b,
  input  logic [2*DW-1:0]     mult_result,
  input  logic                mult_ready,
  output logic                busy,
  output logic                timeout_err
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_RESP} state_t;

  state_t            state_reg, state_next;
  logic [IDW-1:0]    ptr_reg, ptr_next;
  logic [IDW-1:0]    id_reg, id_next;
  logic [DW-1:0]     a_reg, a_next, b_reg, b_next;
  logic [2*DW-1:0]   rsp_data_reg, rsp_data_next;
  logic [IDW-1:0]    rsp_id_reg, rsp_id_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              timeout_reg, timeout_next;
  logic [N_REQ-1:0]  req_ready_int;

  // Requests are rotated so that slot 0 is the requester at ptr.
  logic [IDW-1:0]    rot_idx   [N_REQ];
  logic [N_REQ-1:0]  rot_valid;
  logic [DW-1:0]     a_arr     [N_REQ];
  logic [DW-1:0]     b_arr     [N_REQ];
  logic [IDW-1:0]    grant_id;
  logic              grant_found;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign rot_idx[gi]   = IDW'((int'(ptr_reg) + gi) % N_REQ);
      assign rot_valid[gi] = req_valid[rot_idx[gi]];
      assign a_arr[gi]     = req_a[gi*DW +: DW];
      assign b_arr[gi]     = req_b[gi*DW +: DW];
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        grant_found = 1'b1;
        grant_id    = rot_idx[k];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    id_next       = id_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    rsp_data_next = rsp_data_reg;
    rsp_id_next   = rsp_id_reg;
    cnt_next      = cnt_reg;
    timeout_next  = timeout_reg;
    req_ready_int = '0;
    case (state_reg)
      S_IDLE: begin
        if (grant_found && mult_ready) begin
          req_ready_int[grant_id] = 1'b1;
          id_next    = grant_id;
          a_next     = a_arr[grant_id];
          b_next     = b_arr[grant_id];
          ptr_next   = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_next   = '0;
        state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        cnt_next = cnt_reg + 1'b1;
        if (!mult_ready) begin
          state_next = S_WAIT_DONE;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          timeout_next = 1'b1;
          state_next   = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        cnt_next = cnt_reg + 1'b1;
        if (mult_ready) begin
          rsp_data_next = mult_result;
          rsp_id_next   = id_reg;
          state_next    = S_RESP;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          timeout_next = 1'b1;
          state_next   = S_IDLE;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      ptr_reg      <= '0;
      id_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      rsp_data_reg <= '0;
      rsp_id_reg   <= '0;
      cnt_reg      <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      id_reg       <= id_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      rsp_data_reg <= rsp_data_next;
      rsp_id_reg   <= rsp_id_next;
      cnt_reg      <= cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  // The grant is combinational, so it must be masked explicitly while reset is held.
  assign req_ready   = rst ? '0 : req_ready_int;
  assign mult_start  = (state_reg == S_ISSUE);
  assign rsp_valid   = (state_reg == S_RESP);
  assign busy        = (state_reg != S_IDLE);
  assign mult_a      = a_reg;
  assign mult_b      = b_reg;
  assign rsp_id      = rsp_id_reg;
  assign rsp_data    = rsp_data_reg;
  assign timeout_err = timeout_reg;

endmodule
